// File: rtl/addsub_acc_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_acc_pipe_if
//  Purpose  : Handshake and data bundle for addsub_acc_pipe. Carries the
//             operand stream (in_valid/in_ready, op, sat_en, dataa, datab)
//             and the result stream (out_valid/out_ready, result, carry,
//             overflow) plus the accumulator observation port (acc).
//  Modports : master - operand source / result consumer side
//             slave  - arithmetic unit side
//  Revision : 1.0 - initial release
// ============================================================================
interface addsub_acc_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             sat_en;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, sat_en, dataa, datab, out_ready,
    input  in_ready, out_valid, result, carry, overflow, acc
  );

  modport slave (
    input  in_valid, op, sat_en, dataa, datab, out_ready,
    output in_ready, out_valid, result, carry, overflow, acc
  );
endinterface
`default_nettype wire

// File: rtl/addsub_acc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_acc_pipe
//  Purpose  : Registered WIDTH-bit add/subtract unit with accumulator,
//             optional signed saturation, carry/overflow flags and a
//             valid/ready handshake on both operand and result sides.
//  Ports    : clk   - clock, all state changes on rising edge
//             rst_n - synchronous active-low reset
//             bus   - addsub_acc_pipe_if.slave (operand stream, result
//                     stream, accumulator value)
//  Params   : WIDTH   - operand/result/accumulator width (>= 2)
//             ACC_RST - accumulator value after reset
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_acc_pipe #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] ACC_RST = '0
) (
  input  wire                   clk,
  input  wire                   rst_n,
  addsub_acc_pipe_if.slave      bus
);

  localparam logic [1:0] c_op_add  = 2'b00;
  localparam logic [1:0] c_op_sub  = 2'b01;
  localparam logic [1:0] c_op_acc  = 2'b10;
  localparam logic [1:0] c_op_load = 2'b11;

  localparam int               c_msb     = WIDTH - 1;
  localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic [WIDTH-1:0] r_acc;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH:0]   w_raw;
  logic             w_lhs_sign;
  logic             w_ovf;
  logic             w_carry;
  logic [WIDTH-1:0] w_res;
  logic             w_acc_upd;

  // Single output stage: a new operand fits whenever the stage is empty or
  // is being drained in this same cycle.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Arithmetic at WIDTH+1 bits; bit WIDTH of a subtraction is the borrow.
  always_comb begin
    w_raw      = '0;
    w_lhs_sign = bus.dataa[c_msb];
    w_ovf      = 1'b0;
    w_acc_upd  = 1'b0;
    case (bus.op)
      c_op_add: begin
        w_raw = {1'b0, bus.dataa} + {1'b0, bus.datab};
        w_ovf = (bus.dataa[c_msb] == bus.datab[c_msb]) &&
                (w_raw[c_msb] != bus.dataa[c_msb]);
      end
      c_op_sub: begin
        w_raw = {1'b0, bus.dataa} - {1'b0, bus.datab};
        w_ovf = (bus.dataa[c_msb] != bus.datab[c_msb]) &&
                (w_raw[c_msb] != bus.dataa[c_msb]);
      end
      c_op_acc: begin
        w_raw      = {1'b0, r_acc} + {1'b0, bus.dataa};
        w_lhs_sign = r_acc[c_msb];
        w_ovf      = (r_acc[c_msb] == bus.dataa[c_msb]) &&
                     (w_raw[c_msb] != r_acc[c_msb]);
        w_acc_upd  = 1'b1;
      end
      default: begin  // c_op_load
        w_raw     = {1'b0, bus.dataa};
        w_acc_upd = 1'b1;
      end
    endcase

    w_carry = (bus.op == c_op_load) ? 1'b0 : w_raw[WIDTH];

    // Overflow direction follows the sign of the left operand: for both
    // add and subtract a signed overflow can only push the result away
    // from that sign's range limit.
    w_res = w_raw[WIDTH-1:0];
    if (bus.sat_en && w_ovf) begin
      w_res = w_lhs_sign ? c_sat_min : c_sat_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_acc       <= ACC_RST;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_carry     <= w_carry;
        r_overflow  <= w_ovf;
        if (w_acc_upd) begin
          r_acc <= w_res;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_overflow;
  assign bus.acc       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_addsub_acc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_acc_pipe
//  Purpose  : Directed self-checking bench for addsub_acc_pipe (WIDTH=8,
//             ACC_RST=0): reset, add/sub, saturation, accumulate/load,
//             backpressure, streaming and reset while stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_acc_pipe;

  localparam int WIDTH = 8;

  localparam logic [1:0] c_add  = 2'b00;
  localparam logic [1:0] c_sub  = 2'b01;
  localparam logic [1:0] c_acc  = 2'b10;
  localparam logic [1:0] c_load = 2'b11;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  addsub_acc_pipe_if #(.WIDTH(WIDTH)) bus ();

  addsub_acc_pipe #(
    .WIDTH   (WIDTH),
    .ACC_RST (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs are changed and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic sat);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.dataa    = a;
    bus.datab    = b;
    bus.sat_en   = sat;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = c_add;
    bus.sat_en    = 1'b0;
    bus.dataa     = '0;
    bus.datab     = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
    total++;
    if (bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got c=%b v=%b want 0 0", bus.carry, bus.overflow);
    end
    total++;
    if (bus.acc !== 8'h00) begin bad++; $display("FAIL reset_acc: got %h want 00", bus.acc); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add_sub();
    bus.out_ready = 1'b1;
    drive(c_add, 8'h05, 8'h03, 1'b0);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h08 || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL add_5_3: got v=%b r=%h c=%b o=%b want 1 08 0 0",
                      bus.out_valid, bus.result, bus.carry, bus.overflow);
    end
    drive(c_sub, 8'h03, 8'h05, 1'b0);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'hFE || bus.carry !== 1'b1 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL sub_3_5: got v=%b r=%h c=%b o=%b want 1 fe 1 0",
                      bus.out_valid, bus.result, bus.carry, bus.overflow);
    end
    total++;
    if (bus.acc !== 8'h00) begin bad++; $display("FAIL addsub_acc_untouched: got %h want 00", bus.acc); end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL consume_clears_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    drive(c_add, 8'h70, 8'h20, 1'b1);
    step();
    total++;
    if (bus.result !== 8'h7F || bus.overflow !== 1'b1 || bus.carry !== 1'b0) begin
      bad++; $display("FAIL sat_add_pos: got r=%h o=%b c=%b want 7f 1 0", bus.result, bus.overflow, bus.carry);
    end
    drive(c_sub, 8'h80, 8'h01, 1'b1);
    step();
    total++;
    if (bus.result !== 8'h80 || bus.overflow !== 1'b1 || bus.carry !== 1'b0) begin
      bad++; $display("FAIL sat_sub_neg: got r=%h o=%b c=%b want 80 1 0", bus.result, bus.overflow, bus.carry);
    end
    drive(c_sub, 8'h80, 8'h01, 1'b0);
    step();
    total++;
    if (bus.result !== 8'h7F || bus.overflow !== 1'b1) begin
      bad++; $display("FAIL wrap_sub_neg: got r=%h o=%b want 7f 1", bus.result, bus.overflow);
    end
    drive(c_add, 8'h70, 8'h20, 1'b0);
    step();
    total++;
    if (bus.result !== 8'h90 || bus.overflow !== 1'b1) begin
      bad++; $display("FAIL wrap_add_pos: got r=%h o=%b want 90 1", bus.result, bus.overflow);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_accumulate();
    bus.out_ready = 1'b1;
    drive(c_load, 8'h10, 8'hAA, 1'b1);
    step();
    total++;
    if (bus.acc !== 8'h10 || bus.result !== 8'h10 || bus.carry !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL load_10: got acc=%h r=%h c=%b o=%b want 10 10 0 0",
                      bus.acc, bus.result, bus.carry, bus.overflow);
    end
    drive(c_acc, 8'h05, 8'h00, 1'b0);
    step();
    total++;
    if (bus.acc !== 8'h15 || bus.result !== 8'h15) begin
      bad++; $display("FAIL acc_15: got acc=%h r=%h want 15 15", bus.acc, bus.result);
    end
    drive(c_add, 8'h01, 8'h01, 1'b0);
    step();
    total++;
    if (bus.acc !== 8'h15 || bus.result !== 8'h02) begin
      bad++; $display("FAIL add_between_acc: got acc=%h r=%h want 15 02", bus.acc, bus.result);
    end
    drive(c_acc, 8'h05, 8'h00, 1'b0);
    step();
    total++;
    if (bus.acc !== 8'h1A || bus.result !== 8'h1A) begin
      bad++; $display("FAIL acc_1a: got acc=%h r=%h want 1a 1a", bus.acc, bus.result);
    end
    drive(c_acc, 8'h05, 8'h00, 1'b0);
    step();
    total++;
    if (bus.acc !== 8'h1F || bus.result !== 8'h1F) begin
      bad++; $display("FAIL acc_1f: got acc=%h r=%h want 1f 1f", bus.acc, bus.result);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(c_add, 8'h11, 8'h22, 1'b0);
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 8'h33) begin
      bad++; $display("FAIL bp_first: got v=%b rdy=%b r=%h want 1 0 33",
                      bus.out_valid, bus.in_ready, bus.result);
    end
    drive(c_acc, 8'h40, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (bus.result !== 8'h33 || bus.acc !== 8'h1F || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_%0d: got r=%h acc=%h v=%b rdy=%b want 33 1f 1 0",
                        i, bus.result, bus.acc, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_follows: got %b want 1", bus.in_ready); end
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h5F || bus.acc !== 8'h5F) begin
      bad++; $display("FAIL bp_release: got v=%b r=%h acc=%h want 1 5f 5f",
                      bus.out_valid, bus.result, bus.acc);
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic [7:0] vr [8];
    logic       vc [8];
    va = '{8'h01, 8'h7F, 8'hFF, 8'h80, 8'h10, 8'h20, 8'hC0, 8'h55};
    vb = '{8'h02, 8'h01, 8'h01, 8'h80, 8'hF0, 8'h30, 8'h40, 8'hAA};
    vr = '{8'h03, 8'h80, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00, 8'hFF};
    vc = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(c_add, va[i], vb[i], 1'b0);
      step();
      total++;
      if (bus.out_valid !== 1'b1 || bus.result !== vr[i] || bus.carry !== vc[i]) begin
        bad++; $display("FAIL stream_%0d: got v=%b r=%h c=%b want 1 %h %b",
                        i, bus.out_valid, bus.result, bus.carry, vr[i], vc[i]);
      end
    end
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_end: got v=%b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(c_load, 8'h1F, 8'h00, 1'b0);
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.acc !== 8'h1F || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL rm_setup: got acc=%h v=%b want 1f 1", bus.acc, bus.out_valid);
    end
    // Pulse between edges must not be seen.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    total++;
    if (bus.acc !== 8'h1F || bus.out_valid !== 1'b1 || bus.result !== 8'h1F) begin
      bad++; $display("FAIL rm_glitch: got acc=%h v=%b r=%h want 1f 1 1f", bus.acc, bus.out_valid, bus.result);
    end
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.acc !== 8'h00 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rm_reset: got v=%b r=%h acc=%h rdy=%b want 0 00 00 1",
                      bus.out_valid, bus.result, bus.acc, bus.in_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_sub();
    test_saturation();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
